cmd_init_sequencer: RTL

Parametrised command-stream head stage that sits between a command source and the downstream command link. After every reset it emits a fixed sequence of initialisation words before any upstream traffic. Upstream commands arriving during that sequence are buffered in a small FIFO and forwarded in order afterwards, so reset codes and user commands never interleave or drop.

---
 rtl/cmd_init_sequencer_pkg.sv | 18 +
 rtl/cmd_init_sequencer_fifo.sv | 52 +++++
 rtl/cmd_init_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cmd_init_sequencer_pkg.sv
// Shared types and defaults for the command-stream init sequencer.
package cmd_init_sequencer_pkg;

  typedef enum logic {
    INIT = 1'b0,
    PASS = 1'b1
  } state_t;

  localparam logic [31:0] INIT_CODE_PREAMBLE = 32'hF100_0000;
  localparam logic [31:0] INIT_CODE_RESET    = 32'hF000_0000;
  localparam logic [63:0] DEFAULT_INIT_CODES = {INIT_CODE_PREAMBLE, INIT_CODE_RESET};

  // Index must be able to hold NUM_INIT itself (the "sequence exhausted" value).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cmd_init_sequencer_fifo.sv
// Synchronous power-of-2 FIFO buffering upstream commands; no pop-through at full.
module cmd_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_init_sequencer.sv
// Command-stream head: emits INIT_CODES after reset, then forwards buffered upstream words.
// Optional replay port enabled by defining CMD_INIT_SEQ_REPLAY_EN.
module cmd_init_sequencer
  import cmd_init_sequencer_pkg::*;
#(
  parameter int unsigned                WIDTH      = 32,
  parameter int unsigned                NUM_INIT   = 2,
  parameter logic [NUM_INIT*WIDTH-1:0]  INIT_CODES = DEFAULT_INIT_CODES,
  parameter int unsigned                DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_in_valid,
  output logic             cmd_in_ready,
  input  logic [WIDTH-1:0] cmd_in,
  input  logic             cmd_out_ready,
  output logic             cmd_out_valid,
  output logic [WIDTH-1:0] cmd_out,
  output logic             busy
`ifdef CMD_INIT_SEQ_REPLAY_EN
  ,
  input  logic             replay
`endif
);

  localparam int unsigned    IW   = idx_width(NUM_INIT);
  localparam logic [IW-1:0]  LAST = IW'(NUM_INIT - 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic             valid_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] init_word;
  logic             ld;
  logic             from_init;
  logic             replay_req;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;

`ifdef CMD_INIT_SEQ_REPLAY_EN
  assign replay_req = replay & (state == PASS);
`else
  assign replay_req = 1'b0;
`endif

  assign ld           = ~cmd_out_valid | cmd_out_ready;
  assign from_init    = (state == INIT) && (idx <= LAST);
  assign cmd_in_ready = ~fifo_full;
  assign busy         = (state == INIT);

  cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_in_valid),
    .din   (cmd_in),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    init_word = '0;
    for (int unsigned i = 0; i < NUM_INIT; i++) begin
      if (idx == IW'(i)) init_word = INIT_CODES[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      idx           <= IW'(1);
      cmd_out_valid <= 1'b1;
      cmd_out       <= INIT_CODES[WIDTH-1:0];
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      cmd_out_valid <= valid_nxt;
      cmd_out       <= out_nxt;
    end
  end

  // Index past the table (NUM_INIT = 1 after reset) means the init run is already complete.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (replay_req) begin
      state_nxt = INIT;
      idx_nxt   = '0;
    end else if (ld && state == INIT) begin
      if (from_init) begin
        idx_nxt = idx + 1'b1;
        if (idx == LAST) state_nxt = PASS;
      end else begin
        state_nxt = PASS;
      end
    end
  end

  // On a replay edge the current word may retire, but nothing new loads until INIT resumes.
  always_comb begin
    valid_nxt = cmd_out_valid;
    out_nxt   = cmd_out;
    fifo_pop  = 1'b0;
    if (replay_req) begin
      if (ld) valid_nxt = 1'b0;
    end else if (ld) begin
      if (from_init) begin
        out_nxt   = init_word;
        valid_nxt = 1'b1;
      end else if (!fifo_empty) begin
        out_nxt   = fifo_dout;
        valid_nxt = 1'b1;
        fifo_pop  = 1'b1;
      end else begin
        valid_nxt = 1'b0;
      end
    end
  end

endmodule
